bus_arbiter_memory: RTL

- Responder end of the core bus.
- Takes grant_request from up to N_CORES cores and returns grant_given round-robin, one owner at a time.
- Services the owner's byte reads and writes against an on-chip 2**ADDR_W-byte memory.
- Sits between the cores and shared memory; the core is the initiator, this block answers it.

---
 rtl/bus_arbiter_memory.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_memory.sv
// Bus responder for up to N_CORES initiators: round-robin arbitration with a
// tenure limit, followed by byte reads and writes against an on-chip memory.
// One owner at a time. Each tenure is followed by a single turnaround cycle.
module bus_arbiter_memory #(
  parameter int N_CORES    = 2,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int MAX_TENURE = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          grant_request,
  output logic [N_CORES-1:0]          grant_given,
  input  logic [N_CORES-1:0]          rw,
  input  logic [N_CORES*ADDR_W-1:0]   address,
  input  logic [N_CORES*DATA_W-1:0]   data_from_core,
  output logic [DATA_W-1:0]           data_to_core,
  output logic                        busy
);

  localparam int IDX_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W     = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam int MEM_DEPTH = 2 ** ADDR_W;

  localparam logic [IDX_W-1:0] LAST_CORE   = IDX_W'(N_CORES - 1);
  localparam logic [CNT_W-1:0] TENURE_MAX  = CNT_W'(MAX_TENURE);
  localparam logic [CNT_W-1:0] TENURE_LAST = (MAX_TENURE > 0) ? CNT_W'(MAX_TENURE - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_CORES-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    last_owner_q, last_owner_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  logic                owner_rw;
  logic [ADDR_W-1:0]   owner_addr;
  logic [DATA_W-1:0]   owner_wdata;
  logic                owner_req;
  logic                others_req;
  logic                any_req;
  logic                tenure_hit;
  logic                release_bus;
  logic                mem_we;
  logic [IDX_W-1:0]    winner_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic                found;

  // Route only the current owner's bus signals inward; everyone else is ignored
  always_comb begin
    owner_rw    = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    owner_req   = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (last_owner_q == IDX_W'(i)) begin
        owner_rw    = rw[i];
        owner_addr  = address[i*ADDR_W +: ADDR_W];
        owner_wdata = data_from_core[i*DATA_W +: DATA_W];
        owner_req   = grant_request[i];
      end
    end
  end

  // Round-robin search starting just after the previous owner, wrapping at N_CORES
  always_comb begin
    winner_idx = last_owner_q;
    found      = 1'b0;
    cand_idx   = (last_owner_q == LAST_CORE) ? '0 : last_owner_q + IDX_W'(1);
    for (int i = 0; i < N_CORES; i++) begin
      if (!found && grant_request[cand_idx]) begin
        winner_idx = cand_idx;
        found      = 1'b1;
      end
      cand_idx = (cand_idx == LAST_CORE) ? '0 : cand_idx + IDX_W'(1);
    end
  end

  // Release decision: the owner lets go, or it has used up its tenure while someone waits
  always_comb begin
    any_req     = |grant_request;
    others_req  = |(grant_request & ~grant_q);
    tenure_hit  = (MAX_TENURE != 0) && (counter_q == TENURE_LAST) && others_req;
    release_bus = !owner_req || tenure_hit;
  end

  // State register plus every other flop; async reset drops the grant at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= LAST_CORE;
      counter_q    <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      counter_q    <= counter_d;
      data_q       <= data_d;
    end
  end

  // Next-state logic: IDLE -> GRANT on any request, GRANT -> TURN on release, TURN -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (release_bus) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: grant vector, owner tracking, tenure count and memory access
  always_comb begin
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    counter_d    = counter_q;
    data_d       = data_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (any_req) begin
          grant_d[winner_idx] = 1'b1;
          last_owner_d        = winner_idx;
          counter_d           = '0;
        end
      end
      GRANT: begin
        mem_we = owner_rw;
        if (!owner_rw) data_d = mem_q[owner_addr];
        counter_d = (counter_q == TENURE_MAX) ? counter_q : counter_q + CNT_W'(1);
        if (release_bus) grant_d = '0;
      end
      TURN: begin
        grant_d = '0;
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  // Byte memory, never reset; writes only happen in GRANT, which async reset leaves immediately
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[owner_addr] <= owner_wdata;
  end

  assign grant_given  = grant_q;
  assign data_to_core = data_q;
  assign busy         = |grant_q;

endmodule
